// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC, drives the instruction memory address, and buffers each
// fetched word with its PC in a small circular queue. The queue head goes to
// decode over a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at the word-aligned target.
//
// Ports:
//   clk            system clock, all state on rising edge
//   reset          synchronous, active-high reset
//   imem_addr      byte address to instruction memory (copy of fetch_pc)
//   imem_data      instruction word returned combinationally for imem_addr
//   redirect_valid one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc    redirect target byte address
//   out_valid      queue head holds a valid instruction
//   out_ready      decode accepts the head this cycle
//   out_instr      instruction at queue head (0 when out_valid=0)
//   out_pc         byte address of out_instr (0 when out_valid=0)
//   align_err      sticky flag: a redirect target had nonzero bits [1:0]
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        align_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          align_err_q;

    logic [31:0] q_pc    [DEPTH];
    logic [31:0] q_instr [DEPTH];

    logic pop;
    logic push;

    always_comb begin
        out_valid = (count != '0);
        pop       = out_valid & out_ready;
        // A full queue may still accept a word when the head leaves this cycle.
        push      = !redirect_valid && ((count < CW'(DEPTH)) || pop);
        imem_addr = fetch_pc;
        align_err = align_err_q;
        out_pc    = 32'h0;
        out_instr = 32'h0;
        if (out_valid) begin
            out_pc    = q_pc[rd_ptr];
            out_instr = q_instr[rd_ptr];
        end
    end

    // Control state. Reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            align_err_q <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                align_err_q <= 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Queue storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= imem_data;
        end
    end

endmodule
